// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Two-requester front end for one single-port synchronous RAM. Requests are
// granted combinationally with round-robin tie-breaking, one RAM access is
// issued per cycle through registered mem_* outputs, and read data is routed
// back to the requesting port three cycles after its grant. An optional fill
// sequencer owns the RAM after reset and writes every word before any
// requester is served.
module ram_port_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int INIT_MODE = 2   // 0: no fill, 1: zero fill, 2: ramp (2*k)
) (
  input  logic              clk,
  input  logic              reset,
  // port 0
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  // port 1
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  // status
  output logic              init_busy,
  // RAM side
  output logic              mem_sel,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  // IDLE is the entry state when no fill is configured; it arbitrates
  // exactly like RUN and hands over to RUN after one cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Read-return tag: travels alongside a read until its data is captured.
  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;

  localparam logic [ADDR_W-1:0] INIT_LAST   = '1;
  localparam state_e            RESET_STATE = (INIT_MODE != 0) ? ST_INIT : ST_IDLE;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_k_q, init_k_d;
  logic              rr_last_q, rr_last_d;
  logic              arb_en;

  logic              mem_sel_q, mem_sel_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;

  tag_t              tag_d, tag1_q, tag2_q;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic [ADDR_W:0]   init_k_x2;
  logic [DATA_W-1:0] init_word;

  // Fill pattern for word k; the ramp truncates 2*k to the data width.
  assign init_k_x2 = {init_k_q, 1'b0};
  assign init_word = (INIT_MODE == 2) ? DATA_W'(init_k_x2) : '0;

  // State register: reset restarts the fill sequence (or enters IDLE).
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (reset) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: INIT ends after the last word is issued; RUN is terminal.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned.
    state_d = state_q;
    unique case (state_q)
      ST_INIT: if (init_k_q == INIT_LAST) state_d = ST_RUN;
      ST_IDLE: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = RESET_STATE;
    endcase
  end

  // Output logic: busy flag and combinational round-robin grants.
  always_comb begin
    init_busy = 1'b0;
    arb_en    = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    case (state_q)
      ST_INIT:         init_busy = 1'b1;
      ST_IDLE, ST_RUN: arb_en    = 1'b1;
      default:         ;
    endcase
    if (arb_en) begin
      if (req0 && req1) begin
        // Tie: the port that did not win last time goes first.
        gnt0 = rr_last_q;
        gnt1 = ~rr_last_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Issue mux: choose what reaches the RAM next cycle and tag reads.
  always_comb begin
    mem_sel_d   = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;   // address and data hold when idle
    mem_din_d   = mem_din_q;
    rr_last_d   = rr_last_q;
    init_k_d    = init_k_q;
    tag_d       = '{valid: 1'b0, port: 1'b0};
    if (init_busy) begin
      mem_sel_d   = 1'b1;
      mem_write_d = 1'b1;
      mem_addr_d  = init_k_q;
      mem_din_d   = init_word;
      init_k_d    = init_k_q + 1'b1;
    end else if (gnt0) begin
      mem_sel_d   = 1'b1;
      mem_write_d = we0;
      mem_addr_d  = addr0;
      mem_din_d   = wdata0;
      rr_last_d   = 1'b0;
      tag_d       = '{valid: ~we0, port: 1'b0};
    end else if (gnt1) begin
      mem_sel_d   = 1'b1;
      mem_write_d = we1;
      mem_addr_d  = addr1;
      mem_din_d   = wdata1;
      rr_last_d   = 1'b1;
      tag_d       = '{valid: ~we1, port: 1'b1};
    end
  end

  // Datapath registers: RAM command, arbitration history, fill counter,
  // the two-stage read tag pipeline and the per-port read data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_sel_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      rr_last_q   <= 1'b1;
      init_k_q    <= '0;
      tag1_q      <= '{valid: 1'b0, port: 1'b0};
      tag2_q      <= '{valid: 1'b0, port: 1'b0};
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      mem_sel_q   <= mem_sel_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      rr_last_q   <= rr_last_d;
      init_k_q    <= init_k_d;
      tag1_q      <= tag_d;
      tag2_q      <= tag1_q;
      // tag2 lines up with the cycle in which mem_dout carries the word.
      rvalid0_q   <= tag2_q.valid & ~tag2_q.port;
      rvalid1_q   <= tag2_q.valid &  tag2_q.port;
      if (tag2_q.valid && !tag2_q.port) rdata0_q <= mem_dout;
      if (tag2_q.valid &&  tag2_q.port) rdata1_q <= mem_dout;
    end
  end

  assign mem_sel   = mem_sel_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Two instances: A fills the RAM with the ramp pattern, B has no fill.
// Each has a behavioural RAM. A cycle monitor predicts grants, busy,
// rvalid and rdata from a reference memory and a queue of due reads.
module tb_ram_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A (ramp fill) ----------------
  logic a_reset, a_req0, a_we0, a_req1, a_we1;
  logic [AW-1:0] a_addr0, a_addr1, a_mem_addr;
  logic [DW-1:0] a_wdata0, a_wdata1, a_rdata0, a_rdata1, a_mem_din, a_mem_dout;
  logic a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_init_busy, a_mem_sel, a_mem_write;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INIT_MODE(2)) dut_a (
    .clk(clk), .reset(a_reset),
    .req0(a_req0), .we0(a_we0), .addr0(a_addr0), .wdata0(a_wdata0),
    .gnt0(a_gnt0), .rvalid0(a_rvalid0), .rdata0(a_rdata0),
    .req1(a_req1), .we1(a_we1), .addr1(a_addr1), .wdata1(a_wdata1),
    .gnt1(a_gnt1), .rvalid1(a_rvalid1), .rdata1(a_rdata1),
    .init_busy(a_init_busy),
    .mem_sel(a_mem_sel), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
    .mem_din(a_mem_din), .mem_dout(a_mem_dout)
  );

  // ---------------- instance B (no fill) ----------------
  logic b_reset, b_req0, b_we0, b_req1, b_we1;
  logic [AW-1:0] b_addr0, b_addr1, b_mem_addr;
  logic [DW-1:0] b_wdata0, b_wdata1, b_rdata0, b_rdata1, b_mem_din, b_mem_dout;
  logic b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_init_busy, b_mem_sel, b_mem_write;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INIT_MODE(0)) dut_b (
    .clk(clk), .reset(b_reset),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0),
    .gnt0(b_gnt0), .rvalid0(b_rvalid0), .rdata0(b_rdata0),
    .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1),
    .gnt1(b_gnt1), .rvalid1(b_rvalid1), .rdata1(b_rdata1),
    .init_busy(b_init_busy),
    .mem_sel(b_mem_sel), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_din(b_mem_din), .mem_dout(b_mem_dout)
  );

  // ---------------- behavioural RAMs ----------------
  logic [DW-1:0] ram_a [DEPTH];
  logic [DW-1:0] ram_b [DEPTH];

  always @(posedge clk) begin
    if (a_mem_sel) begin
      if (a_mem_write) ram_a[a_mem_addr] <= a_mem_din;
      else             a_mem_dout <= ram_a[a_mem_addr];
    end
    if (b_mem_sel) begin
      if (b_mem_write) ram_b[b_mem_addr] <= b_mem_din;
      else             b_mem_dout <= ram_b[b_mem_addr];
    end
  end

  // ---------------- reference model state ----------------
  typedef struct {
    int inst;
    int port;
    int data;
    int due;
  } pend_t;

  pend_t         pq[$];
  logic [DW-1:0] ref_mem [2][DEPTH];
  int            exp_rd   [2][2];
  int            last_g   [2];
  int            init_rem [2];

  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      ram_a[k]      = 8'hEE;
      ram_b[k]      = 8'h00;
      ref_mem[0][k] = 8'h00;
      ref_mem[1][k] = 8'h00;
    end
    for (int i = 0; i < 2; i++) begin
      exp_rd[i][0] = 0;
      exp_rd[i][1] = 0;
      last_g[i]    = 1;
      init_rem[i]  = 0;
    end
    a_mem_dout = '0;
    b_mem_dout = '0;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One cycle of prediction for instance i: returns due now, then either
  // reset the model or predict this cycle's grant and record its effect.
  task automatic monitor(input int i, input logic rst, busy, g0, g1, rv0, rv1,
                         input logic [DW-1:0] rd0, rd1,
                         input logic r0, w0, input logic [AW-1:0] ad0, input logic [DW-1:0] wd0,
                         input logic r1, w1, input logic [AW-1:0] ad1, input logic [DW-1:0] wd1);
    string nm;
    int e_rv0, e_rv1;
    bit busy_e, eg0, eg1;
    nm = (i == 0) ? "A" : "B";
    e_rv0 = 0;
    e_rv1 = 0;
    for (int k = pq.size() - 1; k >= 0; k--) begin
      if (pq[k].inst == i && pq[k].due == cyc) begin
        if (pq[k].port == 0) begin e_rv0 = 1; exp_rd[i][0] = pq[k].data; end
        else                 begin e_rv1 = 1; exp_rd[i][1] = pq[k].data; end
        pq.delete(k);
      end
    end
    check({nm, "_rvalid0"}, int'(rv0), e_rv0);
    check({nm, "_rvalid1"}, int'(rv1), e_rv1);
    check({nm, "_rdata0"}, int'(rd0), exp_rd[i][0]);
    check({nm, "_rdata1"}, int'(rd1), exp_rd[i][1]);
    if (rst) begin
      for (int k = pq.size() - 1; k >= 0; k--)
        if (pq[k].inst == i) pq.delete(k);
      last_g[i]    = 1;
      exp_rd[i][0] = 0;
      exp_rd[i][1] = 0;
      init_rem[i]  = (i == 0) ? DEPTH : 0;
      if (i == 0)
        for (int k = 0; k < DEPTH; k++) ref_mem[0][k] = 8'(2 * k);
    end else begin
      busy_e = (init_rem[i] > 0);
      eg0 = !busy_e && r0 && (!r1 || last_g[i] == 1);
      eg1 = !busy_e && r1 && (!r0 || last_g[i] == 0);
      check({nm, "_init_busy"}, int'(busy), int'(busy_e));
      check({nm, "_gnt0"}, int'(g0), int'(eg0));
      check({nm, "_gnt1"}, int'(g1), int'(eg1));
      if (eg0) begin
        last_g[i] = 0;
        if (w0) ref_mem[i][ad0] = wd0;
        else pq.push_back('{inst: i, port: 0, data: int'(ref_mem[i][ad0]), due: cyc + 3});
      end
      if (eg1) begin
        last_g[i] = 1;
        if (w1) ref_mem[i][ad1] = wd1;
        else pq.push_back('{inst: i, port: 1, data: int'(ref_mem[i][ad1]), due: cyc + 3});
      end
      if (init_rem[i] > 0) init_rem[i]--;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      monitor(0, a_reset, a_init_busy, a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_rdata0, a_rdata1,
              a_req0, a_we0, a_addr0, a_wdata0, a_req1, a_we1, a_addr1, a_wdata1);
      monitor(1, b_reset, b_init_busy, b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_rdata0, b_rdata1,
              b_req0, b_we0, b_addr0, b_wdata0, b_req1, b_we1, b_addr1, b_wdata1);
    end
  end

  // Follows instance A from reset release until init_busy falls: counts
  // busy cycles, checks the fill writes and that nothing else reached the RAM.
  task automatic init_phase(input string tag);
    int busy = 0, wk = 0, bad = 0, early = 0;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      if (a_mem_sel) begin
        if (!a_mem_write) early++;
        else begin
          if (a_mem_addr != 10'(wk) || a_mem_din != 8'(2 * wk)) bad++;
          wk++;
        end
      end
      if (!a_init_busy) break;
      busy++;
      if (a_gnt0 || a_gnt1) early++;
    end
    check({tag, "_busy_cycles"}, busy, DEPTH);
    check({tag, "_fill_writes"}, wk, DEPTH);
    check({tag, "_fill_bad"}, bad, 0);
    check({tag, "_early_access"}, early, 0);
  endtask

  task automatic wait_gnt_a(input int p, input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = (p == 0) ? a_gnt0 : a_gnt1;
    end
    check(name, int'(seen), 1);
  endtask

  task automatic new_req_b(input int p);
    if (p == 0) begin
      b_req0 = 1'b1; b_we0 = 1'($urandom_range(0, 1));
      b_addr0 = 10'($urandom_range(0, 7)); b_wdata0 = 8'($urandom);
    end else begin
      b_req1 = 1'b1; b_we1 = 1'($urandom_range(0, 1));
      b_addr1 = 10'($urandom_range(0, 7)); b_wdata1 = 8'($urandom);
    end
  endtask

  typedef struct {
    bit r0; bit w0; bit [AW-1:0] a0; bit [DW-1:0] d0;
    bit r1; bit w1; bit [AW-1:0] a1; bit [DW-1:0] d1;
    bit g0; bit g1;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int rv, g0c, g1c, both, n0, n1, cycles, gcyc;
    bit g0s, g1s;

    // arbitration vectors for instance B, starting from rr_last = 1
    tbl[0] = '{1, 1, 10'h010, 8'h11, 1, 1, 10'h020, 8'h22, 1, 0};
    tbl[1] = '{1, 0, 10'h010, 8'h00, 1, 1, 10'h020, 8'h22, 0, 1};
    tbl[2] = '{1, 0, 10'h010, 8'h00, 1, 0, 10'h020, 8'h00, 1, 0};
    tbl[3] = '{0, 0, 10'h000, 8'h00, 1, 0, 10'h020, 8'h00, 0, 1};
    tbl[4] = '{1, 1, 10'h030, 8'h33, 0, 0, 10'h000, 8'h00, 1, 0};
    tbl[5] = '{0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0};
    tbl[6] = '{1, 0, 10'h030, 8'h00, 1, 0, 10'h010, 8'h00, 0, 1};
    tbl[7] = '{1, 0, 10'h030, 8'h00, 1, 0, 10'h010, 8'h00, 1, 0};
    tbl[8] = '{1, 0, 10'h020, 8'h00, 0, 0, 10'h000, 8'h00, 1, 0};
    tbl[9] = '{1, 0, 10'h020, 8'h00, 1, 1, 10'h3FF, 8'h5A, 0, 1};

    a_reset = 1'b1; b_reset = 1'b1;
    a_req0 = 0; a_we0 = 0; a_addr0 = '0; a_wdata0 = '0;
    a_req1 = 0; a_we1 = 0; a_addr1 = '0; a_wdata1 = '0;
    b_req0 = 0; b_we0 = 0; b_addr0 = '0; b_wdata0 = '0;
    b_req1 = 0; b_we1 = 0; b_addr1 = '0; b_wdata1 = '0;

    // reset state
    @(posedge clk); #1; mon_en = 1'b1;
    @(negedge clk);
    check("rst_mem_sel", int'(a_mem_sel), 0);
    check("rst_mem_write", int'(a_mem_write), 0);
    check("rst_mem_addr", int'(a_mem_addr), 0);
    check("rst_mem_din", int'(a_mem_din), 0);
    check("rst_init_busy_a", int'(a_init_busy), 1);
    check("rst_init_busy_b", int'(b_init_busy), 0);
    check("rst_mem_sel_b", int'(b_mem_sel), 0);

    // T1 + T4: port 0 waits through the fill, then reads address 5
    @(posedge clk); #1;
    a_reset = 1'b0; b_reset = 1'b0;
    a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 10'd5;
    init_phase("t1");
    check("t4_first_gnt0", int'(a_gnt0), 1);
    @(posedge clk); #1; a_req0 = 1'b0;
    @(negedge clk); check("t1_rvalid_n1", int'(a_rvalid0), 0);
    @(negedge clk); check("t1_rvalid_n2", int'(a_rvalid0), 0);
    @(negedge clk); check("t1_rvalid_n3", int'(a_rvalid0), 1);
    check("t1_rdata0", int'(a_rdata0), 10);

    // T2: both ports held, reads of 1 and 2
    @(posedge clk); #1;
    a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 10'd1;
    a_req1 = 1'b1; a_we1 = 1'b0; a_addr1 = 10'd2;
    g0c = 0; g1c = 0; both = 0;
    repeat (10) begin
      @(negedge clk);
      g0c += int'(a_gnt0);
      g1c += int'(a_gnt1);
      if (a_gnt0 && a_gnt1) both++;
    end
    @(posedge clk); #1; a_req0 = 1'b0; a_req1 = 1'b0;
    repeat (4) @(negedge clk);
    check("t2_gnt0_count", g0c, 5);
    check("t2_gnt1_count", g1c, 5);
    check("t2_double_gnt", both, 0);
    check("t2_rdata0", int'(a_rdata0), 2);
    check("t2_rdata1", int'(a_rdata1), 4);

    // T3: write 0xA5 to 1023 then read it back on the next cycle
    @(posedge clk); #1;
    a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 10'd1023; a_wdata1 = 8'hA5;
    wait_gnt_a(1, "t3_write_gnt");
    @(posedge clk); #1; a_we1 = 1'b0;
    wait_gnt_a(1, "t3_read_gnt");
    @(posedge clk); #1; a_req1 = 1'b0;
    @(negedge clk);
    @(negedge clk); check("t3_rvalid_n2", int'(a_rvalid1), 0);
    @(negedge clk); check("t3_rvalid_n3", int'(a_rvalid1), 1);
    check("t3_rdata1", int'(a_rdata1), 8'hA5);
    check("t3_rdata0_held", int'(a_rdata0), 2);

    // T5: reset with a read in flight, then again at fill word 500
    @(posedge clk); #1;
    a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 10'd7;
    wait_gnt_a(0, "t5_read_gnt");
    @(posedge clk); #1; a_reset = 1'b1; a_req0 = 1'b0;
    @(posedge clk); #1; a_reset = 1'b0;
    rv = 0;
    repeat (500) begin
      @(negedge clk);
      rv += int'(a_rvalid0 | a_rvalid1);
    end
    check("t5_inflight_dropped", rv, 0);
    @(posedge clk); #1; a_reset = 1'b1;
    @(posedge clk); #1; a_reset = 1'b0;
    init_phase("t5");

    // table-driven arbitration on instance B
    for (int v = 0; v < 10; v++) begin
      @(posedge clk); #1;
      b_req0 = tbl[v].r0; b_we0 = tbl[v].w0; b_addr0 = tbl[v].a0; b_wdata0 = tbl[v].d0;
      b_req1 = tbl[v].r1; b_we1 = tbl[v].w1; b_addr1 = tbl[v].a1; b_wdata1 = tbl[v].d1;
      @(negedge clk);
      check($sformatf("tbl%0d_gnt0", v), int'(b_gnt0), int'(tbl[v].g0));
      check($sformatf("tbl%0d_gnt1", v), int'(b_gnt1), int'(tbl[v].g1));
    end
    @(posedge clk); #1; b_req0 = 1'b0; b_req1 = 1'b0;
    repeat (4) @(negedge clk);

    // T6: 20 random accesses per port, requests held until granted
    @(posedge clk); #1;
    new_req_b(0);
    new_req_b(1);
    n0 = 0; n1 = 0; cycles = 0; gcyc = 0;
    for (int c = 0; c < 200 && (n0 < 20 || n1 < 20); c++) begin
      @(negedge clk);
      g0s = b_gnt0;
      g1s = b_gnt1;
      cycles++;
      if (g0s || g1s) gcyc++;
      if (g0s) n0++;
      if (g1s) n1++;
      @(posedge clk); #1;
      if (g0s) begin if (n0 < 20) new_req_b(0); else b_req0 = 1'b0; end
      if (g1s) begin if (n1 < 20) new_req_b(1); else b_req1 = 1'b0; end
    end
    b_req0 = 1'b0; b_req1 = 1'b0;
    check("t6_port0_accesses", n0, 20);
    check("t6_port1_accesses", n1, 20);
    check("t6_cycles", cycles, 40);
    check("t6_grant_every_cycle", gcyc, cycles);
    repeat (5) @(negedge clk);
    check("pending_reads", pq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
